// File: rtl/jtpang_pkg.sv
// Shared types and helpers for the jtpang SDRAM bank read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtpang_pkg;

    // Arbiter FSM: wait for a miss, hold the bank request, collect the burst.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int BANK_AW = 22;

    // Client data widths the cache layout can serve.
    function automatic bit dw_valid(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32);
    endfunction

    // Number of 16-bit SDRAM words per fill.
    function automatic int burst_len(input int dw);
        return (dw == 32) ? 2 : 1;
    endfunction

endpackage

// File: rtl/jtpang_rr_pick.sv
// Round-robin selector: first request at or after the pointer, wrapping at N-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module jtpang_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    int            pos;
    logic [IW-1:0] k;
    logic          found;

    // Walk the request vector starting at the pointer and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= N) pos = pos - N;
            k = IW'(pos);
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/jtpang_rom_arb.sv
// N-client SDRAM bank read arbiter with a one-entry tag/data cache per client.
// Latency: hits are combinational; a miss raises ba_rd one cycle after IDLE, ok the cycle after ba_rdy.
// Backpressure: ba_rd/ba_addr held until ba_ack; clients hold cs until ok. JTPANG_ROMARB_PRIO_EN gives client 0 fixed priority.
module jtpang_rom_arb
    import jtpang_pkg::*;
#(
    parameter int          CLIENTS = 4,
    parameter int          AW      = 20,
    parameter int          DW      = 16,
    parameter logic [21:0] BASE    = 22'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CLIENTS-1:0]    cs,
    input  logic [CLIENTS*AW-1:0] addr,
    output logic [CLIENTS-1:0]    ok,
    output logic [CLIENTS*DW-1:0] dout,
    output logic [21:0]           ba_addr,
    output logic                  ba_rd,
    input  logic                  ba_ack,
    input  logic                  ba_dst,
    input  logic                  ba_dok,
    input  logic                  ba_rdy,
    input  logic [15:0]           data_read
);

    localparam int GW    = $clog2(CLIENTS);
    // An unsupported width falls back to single-word fills.
    localparam int WORDS = dw_valid(DW) ? burst_len(DW) : 1;

    arb_state_e                          state_q, state_d;
    logic [GW-1:0]                       grant_q;
    logic [GW-1:0]                       rr_q;
    logic [GW-1:0]                       rr_nxt;
    logic [CLIENTS-1:0]                  valid_q;
    logic [CLIENTS-1:0][AW-1:0]          tag_q;
    logic [CLIENTS-1:0][WORDS*16-1:0]    data_q;
    logic                                wcnt_q;
    logic                                widx;
    logic                                ba_rd_q;
    logic [21:0]                         ba_addr_q;

    logic                                busy;
    logic [CLIENTS-1:0]                  hit;
    logic [CLIENTS-1:0]                  miss;
    logic [CLIENTS-1:0]                  pick_oh;
    logic [GW-1:0]                       pick_idx;
    logic [GW-1:0]                       sel_idx;
    logic                                sel_vld;
    logic [AW-1:0]                       sel_addr;
    logic [21:0]                         sel_wa;

    assign busy    = (state_q != IDLE);
    assign ba_rd   = ba_rd_q;
    assign ba_addr = ba_addr_q;
    assign ok      = hit;

    // Per-client cache lookup and data presentation.
    for (genvar k = 0; k < CLIENTS; k++) begin : g_client
        // The client being filled is never counted as a miss again.
        assign hit[k]  = cs[k] & valid_q[k] & (tag_q[k] == addr[k*AW +: AW]);
        assign miss[k] = cs[k] & ~hit[k] & ~(busy & (grant_q == GW'(k)));

        if (DW == 8) begin : g_dw8
            assign dout[k*DW +: DW] = addr[k*AW] ? data_q[k][15:8] : data_q[k][7:0];
        end else if (DW == 32) begin : g_dw32
            assign dout[k*DW +: DW] = data_q[k];
        end else begin : g_dw16
            assign dout[k*DW +: DW] = data_q[k][15:0];
        end
    end

    jtpang_rr_pick #(
        .N  (CLIENTS),
        .IW (GW)
    ) u_pick (
        .req_i (miss),
        .ptr_i (rr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx)
    );

    // Choose the client to serve next and translate its address to bank words.
    always_comb begin
        sel_vld = |pick_oh;
        sel_idx = pick_idx;
`ifdef JTPANG_ROMARB_PRIO_EN
        if (miss[0]) sel_idx = '0;
`endif
        sel_addr = addr[int'(sel_idx)*AW +: AW];
        sel_wa   = 22'(sel_addr);
        if (DW == 8)       sel_wa = sel_wa >> 1;
        else if (DW == 32) sel_wa = sel_wa << 1;
    end

    // Burst word slot: ba_dst restarts at word 0, otherwise follow the counter.
    assign widx   = ba_dst ? 1'b0 : wcnt_q;
    assign rr_nxt = (grant_q == GW'(CLIENTS-1)) ? '0 : grant_q + 1'b1;

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_vld) state_d = REQ;
            REQ:     if (ba_ack)  state_d = DATA;
            DATA:    if (ba_rdy)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Grant latching, bank handshake and cache fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            valid_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            wcnt_q    <= 1'b0;
            ba_rd_q   <= 1'b0;
            ba_addr_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        grant_q          <= sel_idx;
                        tag_q[sel_idx]   <= sel_addr;
                        valid_q[sel_idx] <= 1'b0;
                        ba_rd_q          <= 1'b1;
                        ba_addr_q        <= BASE + sel_wa;
                        wcnt_q           <= 1'b0;
                    end
                end
                REQ: begin
                    if (ba_ack) ba_rd_q <= 1'b0;
                end
                DATA: begin
                    if (ba_dok) begin
                        if (WORDS == 2 && widx) data_q[grant_q][WORDS*16-1 -: 16] <= data_read;
                        else                    data_q[grant_q][15:0]             <= data_read;
                        wcnt_q <= ~widx;
                    end
                    if (ba_rdy) begin
                        valid_q[grant_q] <= 1'b1;
`ifdef JTPANG_ROMARB_PRIO_EN
                        if (grant_q != '0) rr_q <= rr_nxt;
`else
                        rr_q <= rr_nxt;
`endif
                    end
                end
                default: ba_rd_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtpang_rom_arb.sv
// Directed bench for jtpang_rom_arb: a DW=16 instance for most cases, a DW=32 instance for bursts.
// Latency: n/a.
// Backpressure: the bank side is modelled by small ack/data tasks.
module tb_jtpang_rom_arb;

    localparam int N  = 4;
    localparam int AW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    always #5 clk = ~clk;

    // DW=16 instance signals
    logic [N-1:0]    cs;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ok;
    logic [N*16-1:0] dout;
    logic [21:0]     ba_addr;
    logic            ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0]     data_read;

    // DW=32 instance signals
    logic [N-1:0]    cs_w;
    logic [N*AW-1:0] addr_w;
    logic [N-1:0]    ok_w;
    logic [N*32-1:0] dout_w;
    logic [21:0]     ba_addr_w;
    logic            ba_rd_w, ba_ack_w, ba_dst_w, ba_dok_w, ba_rdy_w;
    logic [15:0]     data_read_w;

    int n_chk = 0;
    int n_err = 0;

    jtpang_rom_arb #(.CLIENTS(N), .AW(AW), .DW(16), .BASE(22'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .ok(ok), .dout(dout),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst),
        .ba_dok(ba_dok), .ba_rdy(ba_rdy), .data_read(data_read)
    );

    jtpang_rom_arb #(.CLIENTS(N), .AW(AW), .DW(32), .BASE(22'h0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .cs(cs_w), .addr(addr_w), .ok(ok_w), .dout(dout_w),
        .ba_addr(ba_addr_w), .ba_rd(ba_rd_w), .ba_ack(ba_ack_w), .ba_dst(ba_dst_w),
        .ba_dok(ba_dok_w), .ba_rdy(ba_rdy_w), .data_read(data_read_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [19:0] a);
        addr[k*AW +: AW] = a;
    endtask

    task automatic wait_rd(output logic [21:0] a);
        int n;
        n = 0;
        while (!ba_rd && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("rd_timeout", 64'(ba_rd), 64'd1);
        a = ba_addr;
    endtask

    task automatic do_ack();
        tick();
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        chk("rd_drop_on_ack", 64'(ba_rd), 64'd0);
    endtask

    task automatic do_data(input logic [15:0] w);
        tick();
        tick();
        ba_dst    = 1'b1;
        ba_dok    = 1'b1;
        ba_rdy    = 1'b1;
        data_read = w;
        tick();
        ba_dst    = 1'b0;
        ba_dok    = 1'b0;
        ba_rdy    = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [21:0] exp_a, input logic [15:0] w);
        logic [21:0] a;
        wait_rd(a);
        chk(tag, 64'(a), 64'(exp_a));
        do_ack();
        do_data(w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cs    = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          seen;
        logic [21:0] a;
        int          n;

        rst_n = 1'b0;
        cs = 4'hF; addr = '0;
        ba_ack = 0; ba_dst = 0; ba_dok = 0; ba_rdy = 0; data_read = '0;
        cs_w = 4'hF; addr_w = '0;
        ba_ack_w = 0; ba_dst_w = 0; ba_dok_w = 0; ba_rdy_w = 0; data_read_w = '0;

        // Reset held with all clients requesting
        repeat (3) begin
            tick();
            chk("rst_ba_rd", 64'(ba_rd), 64'd0);
            chk("rst_ok", 64'(ok), 64'd0);
            chk("rst_dout", dout, 64'd0);
            chk("rst_ba_rd32", 64'(ba_rd_w), 64'd0);
        end
        cs = '0; cs_w = '0;
        tick();
        rst_n = 1'b1;

        // Single miss then hit
        set_addr(1, 20'h00123);
        cs = 4'b0010;
        serve("single_addr", 22'h000123, 16'hBEEF);
        chk("single_ok", 64'(ok), 64'b0010);
        chk("single_dout", 64'(dout[31:16]), 64'hBEEF);
        cs = '0;
        #1 chk("cs_low_ok", 64'(ok), 64'd0);
        cs = 4'b0010;
        #1 chk("rehit_ok", 64'(ok), 64'b0010);
        seen = 0;
        repeat (5) begin
            tick();
            if (ba_rd) seen++;
        end
        chk("hit_no_rd", 64'(seen), 64'd0);

        // Stray dok outside a burst leaves the cache alone
        ba_dok = 1'b1; ba_dst = 1'b1; data_read = 16'hDEAD;
        tick();
        ba_dok = 1'b0; ba_dst = 1'b0;
        tick();
        chk("stray_dok", 64'(dout[31:16]), 64'hBEEF);

        // DW=32 two-word burst
        addr_w[19:0] = 20'h00010;
        cs_w = 4'b0001;
        n = 0;
        while (!ba_rd_w && n < 40) begin tick(); n++; end
        chk("dw32_rd", 64'(ba_rd_w), 64'd1);
        chk("dw32_addr", 64'(ba_addr_w), 64'h20);
        tick(); ba_ack_w = 1'b1;
        tick(); ba_ack_w = 1'b0;
        tick();
        ba_dst_w = 1'b1; ba_dok_w = 1'b1; data_read_w = 16'h1111;
        tick();
        ba_dst_w = 1'b0; data_read_w = 16'h2222; ba_rdy_w = 1'b1;
        tick();
        ba_dok_w = 1'b0; ba_rdy_w = 1'b0;
        chk("dw32_ok", 64'(ok_w), 64'b0001);
        chk("dw32_dout", 64'(dout_w[31:0]), 64'h2222_1111);

        // Round-robin from rr=0, all four missing
        do_reset();
        for (int k = 0; k < N; k++) set_addr(k, 20'h00100 + 20'(k));
        cs = 4'hF;
        for (int k = 0; k < N; k++) serve("rr_order", 22'h100 + 22'(k), 16'hA000 + 16'(k));
        chk("rr_all_ok", 64'(ok), 64'hF);
        chk("rr_all_dout", dout, 64'hA003_A002_A001_A000);
        set_addr(0, 20'h00200);
        set_addr(2, 20'h00202);
        #1 chk("rr_partial_ok", 64'(ok), 64'b1010);
        serve("rr_remiss0", 22'h200, 16'hB000);
        serve("rr_remiss2", 22'h202, 16'hB002);
        chk("rr_remiss_ok", 64'(ok), 64'hF);

        // Address change after ack: fill uses the latched tag, client re-queued
        do_reset();
        set_addr(2, 20'h00005);
        cs = 4'b0100;
        wait_rd(a);
        chk("chg_addr_first", 64'(a), 64'h5);
        do_ack();
        set_addr(2, 20'h00006);
        do_data(16'h5555);
        chk("chg_ok_low", 64'(ok), 64'd0);
        serve("chg_addr_second", 22'h6, 16'h6666);
        chk("chg_ok", 64'(ok), 64'b0100);
        chk("chg_dout", 64'(dout[47:32]), 64'h6666);

        // cs drops mid-burst: fill completes, ok follows cs
        do_reset();
        set_addr(3, 20'h00007);
        cs = 4'b1000;
        wait_rd(a);
        do_ack();
        cs = '0;
        do_data(16'h7777);
        chk("csdrop_ok_low", 64'(ok), 64'd0);
        cs = 4'b1000;
        #1 chk("csdrop_ok", 64'(ok), 64'b1000);
        chk("csdrop_dout", 64'(dout[63:48]), 64'h7777);

        // rr=2, misses on 0, 1 and 3
        do_reset();
        set_addr(1, 20'h00300);
        cs = 4'b0010;
        serve("prio_setup", 22'h300, 16'hC001);
        set_addr(0, 20'h00400);
        set_addr(1, 20'h00401);
        set_addr(3, 20'h00403);
        cs = 4'b1011;
`ifdef JTPANG_ROMARB_PRIO_EN
        serve("prio_first", 22'h400, 16'hD000);
        serve("prio_second", 22'h403, 16'hD003);
        serve("prio_third", 22'h401, 16'hD001);
`else
        serve("rr2_first", 22'h403, 16'hD003);
        serve("rr2_second", 22'h400, 16'hD000);
        serve("rr2_third", 22'h401, 16'hD001);
`endif
        chk("rr2_ok", 64'(ok), 64'b1011);

        // Reset mid-request drops ba_rd on the next edge
        set_addr(0, 20'h00500);
        wait_rd(a);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_rd", 64'(ba_rd), 64'd0);
        chk("rst_mid_ok", 64'(ok), 64'd0);
        rst_n = 1'b1;
        cs = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
